// File: rtl/thresh_scan.sv
// Raster-scans a WIDTH x HEIGHT frame buffer and streams one thresholded pixel per
// valid/ready handshake, with start/busy/done control around each frame.
module thresh_scan #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 10,
    parameter int PIX_W  = 8,
    localparam int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [PIX_W-1:0]  thresh_lo,
    input  logic [PIX_W-1:0]  thresh_hi,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_pixel,
    output logic [15:0]       out_row,
    output logic [15:0]       out_col,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, READ, EVAL, OUT, FIN} state_t;

    state_t            state, state_nxt;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic [1:0]        mode_q;
    logic [PIX_W-1:0]  lo_q, hi_q;
    logic [PIX_W-1:0]  result;
    logic              last_pix;
    logic              accept;

    assign last_pix = (row == RW'(HEIGHT - 1)) && (col == CW'(WIDTH - 1));
    assign accept   = (state == OUT) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    state_nxt = EVAL;
            EVAL:    state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = last_pix ? FIN : READ;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Settings are only sampled on frame start so mid-frame input changes are inert.
    always_comb begin
        result = '0;
        case (mode_q)
            2'd0:    result = (rd_data > lo_q) ? '1 : '0;
            2'd1:    result = (rd_data > lo_q) ? '0 : '1;
            2'd2:    result = (rd_data >= lo_q && rd_data <= hi_q) ? '1 : '0;
            default: result = (rd_data > lo_q) ? lo_q : rd_data;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            row       <= '0;
            col       <= '0;
            out_pixel <= '0;
        end else begin
            if (state == IDLE && start) begin
                mode_q <= mode;
                lo_q   <= thresh_lo;
                hi_q   <= thresh_hi;
                row    <= '0;
                col    <= '0;
            end
            if (state == EVAL)
                out_pixel <= result;
            if (accept && !last_pix) begin
                if (col == CW'(WIDTH - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign rd_en     = (state == READ);
    assign rd_addr   = rd_en ? ADDR_W'(row) * ADDR_W'(WIDTH) + ADDR_W'(col) : '0;
    assign out_valid = (state == OUT);
    assign out_row   = 16'(row);
    assign out_col   = 16'(col);
    assign out_last  = out_valid && last_pix;
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);

endmodule

// File: tb/tb_thresh_scan.sv
// Directed bench for thresh_scan on a 4x4 frame whose pixel i holds i*16.
module tb_thresh_scan;
    localparam int W = 4, H = 4, P = 8, A = 4;

    logic         clk = 1'b0;
    logic         rst, start, out_ready;
    logic [1:0]   mode;
    logic [P-1:0] thresh_lo, thresh_hi, rd_data, out_pixel;
    logic         rd_en, out_valid, out_last, busy, done;
    logic [A-1:0] rd_addr;
    logic [15:0]  out_row, out_col;

    thresh_scan #(.WIDTH(W), .HEIGHT(H), .PIX_W(P)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .thresh_lo(thresh_lo), .thresh_hi(thresh_hi),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [P-1:0] mem [W*H];
    initial for (int i = 0; i < W*H; i++) mem[i] = 8'(i * 16);

    always_ff @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int n_cmp = 0, n_bad = 0;
    logic [P-1:0] got [W*H];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [P-1:0] model(input logic [1:0] m, input logic [P-1:0] l,
                                           input logic [P-1:0] h, input logic [P-1:0] p);
        case (m)
            2'd0:    return (p > l) ? 8'hff : 8'h00;
            2'd1:    return (p > l) ? 8'h00 : 8'hff;
            2'd2:    return (p >= l && p <= h) ? 8'hff : 8'h00;
            default: return (p > l) ? l : p;
        endcase
    endfunction

    // Runs one frame; stall_at>=0 stalls that pixel 5 cycles and pulses start mid-frame,
    // rst_at>=0 asserts reset while that pixel is presented.
    task automatic run_frame(input logic [1:0] m, input logic [P-1:0] l, input logic [P-1:0] h,
                             input int stall_at, input int rst_at);
        int n = 0, cyc = 0, stall = 0, rdc = 0, done_cyc = -1;
        logic [P-1:0] hp;
        logic [15:0]  hr, hc;
        bit fin = 0;
        @(negedge clk);
        mode = m; thresh_lo = l; thresh_hi = h; start = 1'b1; out_ready = 1'b1;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (stall_at >= 0 && cyc == 10) begin
                start = 1'b1; mode = 2'd1; thresh_lo = 8'd0; thresh_hi = 8'hff;
            end
            if (rd_en) rdc++;
            if (done) begin
                done_cyc = cyc;
                fin = 1;
            end
            out_ready = 1'b1;
            if (!fin && out_valid) begin
                if (n == rst_at) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_valid", out_valid, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_rd_en", rd_en, 0);
                    chk("rst_pixel", out_pixel, 0);
                    chk("rst_last", out_last, 0);
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        chk("rst_no_done", done, 0);
                    end
                    rst = 1'b0;
                    @(negedge clk);
                    chk("rst_idle_after", busy, 0);
                    fin = 1;
                end else if (n == stall_at && stall < 5) begin
                    out_ready = 1'b0;
                    if (stall == 0) begin
                        hp = out_pixel; hr = out_row; hc = out_col;
                    end else begin
                        chk("stall_pixel", out_pixel, hp);
                        chk("stall_row", out_row, hr);
                        chk("stall_col", out_col, hc);
                    end
                    chk("stall_no_rd", rd_en, 0);
                    stall++;
                end else begin
                    chk("row", out_row, n / W);
                    chk("col", out_col, n % W);
                    chk("last", out_last, (n == W*H - 1) ? 1 : 0);
                    chk("pixel", out_pixel, model(m, l, h, mem[n]));
                    got[n] = out_pixel;
                    n++;
                end
            end
        end
        if (rst_at < 0) begin
            chk("done_seen", fin, 1);
            chk("frame_count", n, W*H);
            chk("rd_count", rdc, W*H);
            chk("done_cycle", done_cyc, 3*W*H + 1 + (stall_at >= 0 ? 5 : 0));
            @(negedge clk);
            chk("done_pulse", done, 0);
            chk("busy_cleared", busy, 0);
        end else begin
            chk("rst_reached", fin, 1);
            chk("rst_count", n, rst_at);
        end
    endtask

    typedef struct {
        logic [1:0]   mode;
        logic [P-1:0] lo, hi;
        int           idx;
        logic [P-1:0] exp;
    } vec_t;

    vec_t vecs[22];

    initial begin
        vecs[0]  = '{2'd0, 8'd100, 8'd0,   0,  8'd0};
        vecs[1]  = '{2'd0, 8'd100, 8'd0,   6,  8'd0};
        vecs[2]  = '{2'd0, 8'd100, 8'd0,   7,  8'd255};
        vecs[3]  = '{2'd0, 8'd100, 8'd0,   15, 8'd255};
        vecs[4]  = '{2'd1, 8'd100, 8'd0,   6,  8'd255};
        vecs[5]  = '{2'd1, 8'd100, 8'd0,   7,  8'd0};
        vecs[6]  = '{2'd3, 8'd100, 8'd0,   0,  8'd0};
        vecs[7]  = '{2'd3, 8'd100, 8'd0,   6,  8'd96};
        vecs[8]  = '{2'd3, 8'd100, 8'd0,   7,  8'd100};
        vecs[9]  = '{2'd3, 8'd100, 8'd0,   15, 8'd100};
        vecs[10] = '{2'd2, 8'd50,  8'd150, 3,  8'd0};
        vecs[11] = '{2'd2, 8'd50,  8'd150, 4,  8'd255};
        vecs[12] = '{2'd2, 8'd50,  8'd150, 9,  8'd255};
        vecs[13] = '{2'd2, 8'd50,  8'd150, 10, 8'd0};
        vecs[14] = '{2'd2, 8'd48,  8'd144, 2,  8'd0};
        vecs[15] = '{2'd2, 8'd48,  8'd144, 3,  8'd255};
        vecs[16] = '{2'd2, 8'd48,  8'd144, 9,  8'd255};
        vecs[17] = '{2'd2, 8'd48,  8'd144, 10, 8'd0};
        vecs[18] = '{2'd2, 8'd200, 8'd10,  0,  8'd0};
        vecs[19] = '{2'd2, 8'd200, 8'd10,  8,  8'd0};
        vecs[20] = '{2'd0, 8'd96,  8'd0,   6,  8'd0};
        vecs[21] = '{2'd0, 8'd240, 8'd0,   15, 8'd0};

        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        mode = 2'd0; thresh_lo = '0; thresh_hi = '0;
        repeat (2) @(negedge clk);
        chk("reset_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rd_en", rd_en, 0);
        chk("reset_addr", rd_addr, 0);
        chk("reset_pixel", out_pixel, 0);
        chk("reset_rowcol", {out_row, out_col}, 0);
        chk("reset_last", out_last, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ready_noeffect", {busy, out_valid}, 0);

        for (int i = 0; i < 22; i++) begin
            if (i == 0 || vecs[i].mode != vecs[i-1].mode || vecs[i].lo != vecs[i-1].lo ||
                vecs[i].hi != vecs[i-1].hi)
                run_frame(vecs[i].mode, vecs[i].lo, vecs[i].hi, -1, -1);
            chk($sformatf("vec%0d", i), got[vecs[i].idx], vecs[i].exp);
        end

        run_frame(2'd0, 8'd100, 8'd0, 6, -1);
        run_frame(2'd3, 8'd100, 8'd0, -1, 9);
        run_frame(2'd0, 8'd100, 8'd0, -1, -1);
        chk("rescan_first", got[0], 0);
        chk("rescan_last", got[15], 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
